// File: rtl/pipelined_ripple_adder_pkg.sv
// Shared definitions for the pipelined ripple-carry adder/subtractor:
// op encoding, chunk-width derivation and the geometry legality check.
package pipelined_ripple_adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  // Bits handled by each pipeline stage. Guarded so an illegal STAGES value
  // still elaborates far enough to reach the legality error.
  function automatic int chunk_width(input int width, input int stages);
    return (stages >= 1) ? (width / stages) : 1;
  endfunction

  // WIDTH must split into STAGES equal, non-empty chunks.
  function automatic bit geometry_ok(input int width, input int stages);
    return (stages >= 1) && (width >= stages) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/pipelined_ripple_adder_adder_chunk.sv
// Combinational W-bit ripple-carry adder built from a chain of full-adder cells.
module adder_chunk
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/pipelined_ripple_adder.sv
// Pipelined WIDTH-bit ripple adder/subtractor. Each stage adds one CHUNK of
// the operands and registers the carry for the next stage. A single global
// enable (driven by output backpressure) advances or freezes the whole pipe.
//
// Per-stage register k holds:
//   word_q[k]  : sum chunks 0..k in the low bits, untouched A chunks above
//   bsk_q[k]   : Beff shifted down so its lowest chunk feeds stage k+1
//   carry_q[k] : carry out of chunk k
//   am_q/bm_q  : MSBs of A and Beff, needed for the overflow flag at the end
module pipelined_ripple_adder
  import pipelined_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             Cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int MSB   = WIDTH - 1;
  localparam int LAST  = STAGES - 1;
  localparam bit LEGAL = geometry_ok(WIDTH, STAGES);

  if (!LEGAL) begin : g_bad_geometry
    $error("pipelined_ripple_adder: WIDTH=%0d is not a positive multiple of STAGES=%0d",
           WIDTH, STAGES);
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  logic [WIDTH-1:0] word_q  [STAGES];
  logic [WIDTH-1:0] bsk_q   [STAGES];
  logic             carry_q [STAGES];
  logic             valid_q [STAGES];
  logic             am_q    [STAGES];
  logic             bm_q    [STAGES];

  // Bubbles are not collapsed: the pipe moves as a whole whenever the
  // output slot is empty or being drained.
  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  // Subtraction as A + ~B + 1; Cin is ignored in that mode.
  assign b_eff = (sub == SUB) ? ~B : B;
  assign c0    = (sub == SUB) ? 1'b1 : Cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [WIDTH-1:0] word_in;
    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] word_nx;
    logic             c_in;
    logic             v_in;
    logic             am_in;
    logic             bm_in;
    logic [CHUNK-1:0] s_chunk;
    logic             c_out;

    if (k == 0) begin : g_head
      assign word_in = A;
      assign b_in    = b_eff;
      assign c_in    = c0;
      assign v_in    = in_valid;
      assign am_in   = A[MSB];
      assign bm_in   = b_eff[MSB];
    end else begin : g_body
      assign word_in = word_q[k-1];
      assign b_in    = bsk_q[k-1];
      assign c_in    = carry_q[k-1];
      assign v_in    = valid_q[k-1];
      assign am_in   = am_q[k-1];
      assign bm_in   = bm_q[k-1];
    end

    adder_chunk #(
      .W(CHUNK)
    ) u_chunk (
      .a    (word_in[k*CHUNK +: CHUNK]),
      .b    (b_in[CHUNK-1:0]),
      .cin  (c_in),
      .s    (s_chunk),
      .cout (c_out)
    );

    // Replace the A chunk consumed by this stage with its sum chunk.
    always_comb begin
      word_nx                    = word_in;
      word_nx[k*CHUNK +: CHUNK]  = s_chunk;
    end

    // Stage register: clears on reset, advances only with the global enable.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        word_q[k]  <= '0;
        bsk_q[k]   <= '0;
        carry_q[k] <= 1'b0;
        valid_q[k] <= 1'b0;
        am_q[k]    <= 1'b0;
        bm_q[k]    <= 1'b0;
      end else if (en) begin
        word_q[k]  <= word_nx;
        bsk_q[k]   <= b_in >> CHUNK;
        carry_q[k] <= c_out;
        valid_q[k] <= v_in;
        am_q[k]    <= am_in;
        bm_q[k]    <= bm_in;
      end
    end
  end

  assign out_valid = valid_q[LAST];
  assign S         = word_q[LAST];
  assign Cout      = carry_q[LAST];
  assign ovf       = (am_q[LAST] == bm_q[LAST]) && (S[MSB] != am_q[LAST]);

endmodule

// File: tb/tb_pipelined_ripple_adder.sv
// Directed bench for pipelined_ripple_adder: a vector table applied to three
// geometries (16/4, 16/1, 8/2), a backpressure stream and a mid-flight reset.
module tb_pipelined_ripple_adder;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [15:0] s;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        rdy_main;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;

  logic        ir_m, ov_m, co_m, of_m;
  logic [15:0] s_m;
  logic        ir_1, ov_1, co_1, of_1;
  logic [15:0] s_1;
  logic        ir_8, ov_8, co_8, of_8;
  logic [7:0]  s_8;

  int checks = 0;
  int errors = 0;

  vec_t vecs [8];

  always #5 clk = ~clk;

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_m),
    .A(a), .B(b), .Cin(cin), .sub(sub),
    .out_valid(ov_m), .out_ready(rdy_main), .S(s_m), .Cout(co_m), .ovf(of_m)
  );

  pipelined_ripple_adder #(.WIDTH(16), .STAGES(1)) dut_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_1),
    .A(a), .B(b), .Cin(cin), .sub(sub),
    .out_valid(ov_1), .out_ready(1'b1), .S(s_1), .Cout(co_1), .ovf(of_1)
  );

  pipelined_ripple_adder #(.WIDTH(8), .STAGES(2)) dut_w8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(ir_8),
    .A(a[7:0]), .B(b[7:0]), .Cin(cin), .sub(sub),
    .out_valid(ov_8), .out_ready(1'b1), .S(s_8), .Cout(co_8), .ovf(of_8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Word-level reference: returns {ovf, cout, s} for a w-bit operation.
  function automatic logic [17:0] ref_add(input int w, input logic [15:0] x,
                                          input logic [15:0] y, input logic ci,
                                          input logic sb);
    logic [15:0] mask, xm, be, s;
    logic [16:0] full;
    logic        c0, co, ov;
    mask = 16'hFFFF >> (16 - w);
    xm   = x & mask;
    be   = (sb ? ~y : y) & mask;
    c0   = sb ? 1'b1 : ci;
    full = {1'b0, xm} + {1'b0, be} + {16'b0, c0};
    s    = full[15:0] & mask;
    co   = full[w];
    ov   = (xm[w-1] == be[w-1]) && (s[w-1] != xm[w-1]);
    return {ov, co, s};
  endfunction

  // One transaction into all three instances; record latency and result of each.
  task automatic run_vec(input vec_t v);
    int          lat_m, lat_1, lat_8;
    logic [15:0] sm, s1;
    logic [7:0]  s8;
    logic        cm, om, c1, o1, c8, o8;
    logic [17:0] r8;
    lat_m = 0; lat_1 = 0; lat_8 = 0;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub; in_valid = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      @(posedge clk);
      #1;
      if (e == 1) in_valid = 1'b0;
      if (ov_m && lat_m == 0) begin lat_m = e; sm = s_m; cm = co_m; om = of_m; end
      if (ov_1 && lat_1 == 0) begin lat_1 = e; s1 = s_1; c1 = co_1; o1 = of_1; end
      if (ov_8 && lat_8 == 0) begin lat_8 = e; s8 = s_8; c8 = co_8; o8 = of_8; end
    end
    check("lat_s4", lat_m, 4);
    check("s_s4", sm, v.s);
    check("cout_s4", cm, v.cout);
    check("ovf_s4", om, v.ovf);
    check("lat_s1", lat_1, 1);
    check("s_s1", s1, v.s);
    check("cout_s1", c1, v.cout);
    check("ovf_s1", o1, v.ovf);
    r8 = ref_add(8, v.a, v.b, v.cin, v.sub);
    check("lat_w8", lat_8, 2);
    check("s_w8", s8, r8[7:0]);
    check("cout_w8", c8, r8[16]);
    check("ovf_w8", o8, r8[17]);
    check("in_ready_s1", ir_1, 1);
    check("in_ready_w8", ir_8, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] qa [8];
    logic [15:0] qb [8];
    logic        qc [8];
    logic        qs [8];
    logic [17:0] r;
    int          sent, got, stale;
    logic        stall_prev;
    logic [15:0] held_s;
    logic        held_c, held_o;
    vec_t        v;

    //            a        b        cin   sub   s        cout  ovf
    vecs[0] = '{16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; rdy_main = 1'b1;
    a = 16'h0; b = 16'h0; cin = 1'b0; sub = 1'b0;
    #2;
    check("reset_out_valid", ov_m, 0);
    check("reset_s", s_m, 0);
    check("reset_cout", co_m, 0);
    check("reset_ovf", of_m, 0);
    check("reset_in_ready", ir_m, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Back-to-back stream with a 3-cycle output stall in the middle.
    for (int i = 0; i < 8; i++) begin
      qa[i] = 16'($urandom);
      qb[i] = 16'($urandom);
      qc[i] = 1'($urandom);
      qs[i] = 1'($urandom);
    end
    sent = 0; got = 0; stall_prev = 1'b0;
    held_s = '0; held_c = 1'b0; held_o = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      @(negedge clk);
      rdy_main = !(cyc >= 5 && cyc <= 7);
      if (sent < 8) begin
        in_valid = 1'b1; a = qa[sent]; b = qb[sent]; cin = qc[sent]; sub = qs[sent];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_prev) begin
        check("stall_hold_valid", ov_m, 1);
        check("stall_hold_s", s_m, held_s);
        check("stall_hold_cout", co_m, held_c);
        check("stall_hold_ovf", of_m, held_o);
      end
      stall_prev = ov_m && !rdy_main;
      if (stall_prev) begin
        check("stall_in_ready", ir_m, 0);
        held_s = s_m; held_c = co_m; held_o = of_m;
      end
      if (ov_m && rdy_main) begin
        r = ref_add(16, qa[got], qb[got], qc[got], qs[got]);
        check("stream_s", s_m, r[15:0]);
        check("stream_cout", co_m, r[16]);
        check("stream_ovf", of_m, r[17]);
        got++;
      end
      if (in_valid && ir_m) sent++;
    end
    check("stream_count", got, 8);
    in_valid = 1'b0;
    rdy_main = 1'b1;
    repeat (6) @(negedge clk);

    // Reset with transactions in flight and one at the output.
    for (int i = 0; i < 4; i++) begin
      a = 16'h0100 * 16'(i + 1); b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("rst_pre_valid", ov_m, 1);
    check("rst_pre_s", s_m, 16'h0101);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_valid", ov_m, 0);
    check("rst_mid_s", s_m, 0);
    check("rst_mid_cout", co_m, 0);
    check("rst_mid_in_ready", ir_m, 1);
    @(negedge clk);
    rst_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (ov_m) stale++;
    end
    check("rst_stale", stale, 0);
    v = '{16'h0010, 16'h0020, 1'b0, 1'b0, 16'h0030, 1'b0, 1'b0};
    run_vec(v);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipelined_ripple_adder.md
# pipelined_ripple_adder

Parametrised, pipelined ripple-carry adder/subtractor and the successor to the fixed 4-bit ripple adder. It splits a WIDTH-bit operation into STAGES equal chunks and registers the carry between chunks, so one transaction is accepted per cycle at full clock rate. It adds subtract mode, signed-overflow detection and a valid/ready handshake with backpressure. It sits between operand producers and any consumer of arithmetic results in the datapath.

## Interface
- WIDTH, 16, operand/result width in bits; must be an integer multiple of STAGES.
- STAGES, 4, pipeline depth and chunk count; CHUNK = WIDTH/STAGES bits per stage; STAGES ≥ 1.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand transaction present.
- in_ready  output  1  block can accept a transaction this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: S = A + B + Cin; 1: S = A − B (A + ~B + 1).
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- S  output  WIDTH  sum/difference, modulo 2^WIDTH.
- Cout  output  1  carry out of the MSB; in subtract mode 1 = no borrow.
- ovf  output  1  two's-complement signed overflow.

## Operation
- Effective operands: Beff = sub ? ~B : B; c0 = sub ? 1 : Cin.
- Stage k (0..STAGES−1) adds chunk k of A and Beff plus the carry registered by stage k−1 (c0 for stage 0). It registers the CHUNK sum bits and carry-out.
- Skew: chunks k+1..STAGES−1 of A and Beff travel forward in per-stage registers until consumed. Sum chunks 0..k−1 are carried forward so the whole S word emerges aligned at the last stage.
- Cout = carry-out of stage STAGES−1.
- ovf = (A[MSB] == Beff[MSB]) && (S[MSB] != A[MSB]). The MSBs of A and Beff are carried with the transaction.
- Global enable: en = !out_valid || out_ready. When en=1, every stage register and valid bit advances one stage. When en=0, everything holds.
- in_ready = en. A transaction is accepted on an edge where in_valid && in_ready. Stage-0 valid loads in_valid && en.
- Bubbles are not collapsed. An empty stage advances like a full one.
- Transactions leave in acceptance order, with no loss and no duplication.

## Timing
- Reset: asserting rst_n low immediately clears every valid bit, so out_valid=0, and clears all data and carry registers, so S=0, Cout=0, ovf=0. in_ready=1 while in reset and after release.
- Latency: a transaction accepted at edge t drives out_valid=1 with its result after edge t+STAGES−1, i.e. STAGES cycles, provided no stall occurs in between. Each stalled cycle adds one cycle.
- Throughput: 1 transaction per cycle while out_ready=1.
- Stall: while out_valid && !out_ready, the outputs S/Cout/ovf/out_valid are held stable and in_ready=0. A transaction offered during the stall is not taken.
- out_valid && out_ready with in_valid on the same edge: the output is retired, every stage shifts, and the new input is captured. There is no dead cycle.
- Reset mid-operation: all in-flight transactions are discarded. After release, only transactions accepted after release appear.
- STAGES=1: the block is a single registered full-width adder with latency 1.
- Carry wrap: A=all-ones, B=0, Cin=1 must ripple through every stage, giving S=0 and Cout=1.

## Structure
- Shared package: the CHUNK derivation and a legality check constant (WIDTH % STAGES == 0) with an elaboration-time error on violation. It also holds the op encoding constants ADD=1'b0, SUB=1'b1.
- Sub-module adder_chunk: a combinational CHUNK-bit ripple adder built from full-adder cells, with inputs a, b, cin and outputs s, cout. It is instantiated STAGES times by a generate loop.
- The top level owns all pipeline registers, valid bits, skew registers and the handshake.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1, A=0x0001, B=0x0002, Cin=0, sub=0 -> S=0x0003, Cout=0, ovf=0; out_valid rises exactly 4 cycles after acceptance.
- A=0xFFFF, B=0x0000, Cin=1 -> S=0x0000, Cout=1, ovf=0. A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, ovf=1.
- sub=1: A=0x0005, B=0x0007 -> S=0xFFFE, Cout=0, ovf=0. A=0x8000, B=0x0001 -> S=0x7FFF, Cout=1, ovf=1.
- 8 back-to-back random transactions with out_ready low for 3 cycles mid-stream -> all 8 results in order against the reference model; S/out_valid stable during the stall; in_ready=0 during the stall.
- rst_n pulsed low with 3 transactions in flight -> out_valid drops immediately; no stale result after release; next accepted A=0x0010, B=0x0020 -> S=0x0030 after 4 cycles.
- Re-run scenarios 1–3 with STAGES=1 and with WIDTH=8, STAGES=2 -> same arithmetic results; latency 1 and 2 respectively.
